// File: rtl/ram_clr.sv
// ram_clr: single-write, dual-read RAM with combinational reads and a
// hardware clear sweep that zeroes every word, optionally after each reset.
module ram_clr #(
    parameter int WIDTH      = 16,
    parameter int AWIDTH     = 14,
    parameter int INIT_CLEAR = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [WIDTH-1:0]  in,
    input  logic              load,
    input  logic [AWIDTH-1:0] address,
    output logic [WIDTH-1:0]  out,
    input  logic [AWIDTH-1:0] raddr2,
    output logic [WIDTH-1:0]  out2,
    input  logic              clear,
    output logic              busy,
    output logic              done
);
    localparam int DEPTH = 2 ** AWIDTH;
    localparam logic [AWIDTH-1:0] LAST = '1;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state, state_next;
    logic [AWIDTH-1:0] cnt, cnt_next;
    logic              done_next;
    logic [WIDTH-1:0]  m [DEPTH];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= (INIT_CLEAR != 0) ? CLEAR : IDLE;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            done  <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        done_next  = 1'b0;
        if (state == IDLE) begin
            state_next = clear ? CLEAR : IDLE;
            cnt_next   = clear ? '0 : cnt;
        end else begin
            state_next = (cnt == LAST) ? IDLE : CLEAR;
            cnt_next   = (cnt == LAST) ? cnt : cnt + 1'b1;
            done_next  = (cnt == LAST);
        end
    end

    always_comb begin
        busy = (state == CLEAR);
        out  = busy ? '0 : m[address];
        out2 = busy ? '0 : m[raddr2];
    end

    // The array has no reset; writes are merely held off while reset is low.
    always_ff @(posedge clock) begin
        if (reset) begin
            if (state == CLEAR)
                m[cnt] <= '0;
            else if (load && !clear)
                m[address] <= in;
        end
    end
endmodule

// File: tb/tb_ram_clr.sv
// tb_ram_clr: directed, table-driven checks of ram_clr (WIDTH=16, AWIDTH=4),
// plus hand-written sweep, abort and priority sequences.
module tb_ram_clr;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] in = '0;
    logic        load = 1'b0;
    logic [3:0]  address = '0;
    logic [3:0]  raddr2 = '0;
    logic        clear = 1'b0;
    logic [15:0] out, out2, out_nc, out2_nc;
    logic        busy, done, busy_nc, done_nc;

    int checks = 0;
    int errors = 0;

    ram_clr #(.WIDTH(16), .AWIDTH(4), .INIT_CLEAR(1)) dut (
        .clock(clock), .reset(reset), .in(in), .load(load), .address(address),
        .out(out), .raddr2(raddr2), .out2(out2), .clear(clear),
        .busy(busy), .done(done)
    );

    ram_clr #(.WIDTH(16), .AWIDTH(4), .INIT_CLEAR(0)) dut_nc (
        .clock(clock), .reset(reset), .in(in), .load(load), .address(address),
        .out(out_nc), .raddr2(raddr2), .out2(out2_nc), .clear(clear),
        .busy(busy_nc), .done(done_nc)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        ld;
        logic [3:0]  a;
        logic [15:0] d;
        logic [3:0]  r2;
        logic [15:0] eo;
        logic [15:0] eo2;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Runs a fixed 20 edges; n = edge at which busy first reads low,
    // nd = number of done samples, dat = edge of the last done sample.
    task automatic measure(input int clr_at, output int n, output int nd, output int dat);
        n = 0; nd = 0; dat = 0;
        for (int i = 1; i <= 20; i++) begin
            clear = (i == clr_at);
            tick();
            clear = 1'b0;
            if (done) begin nd++; dat = i; end
            if (busy && done) chk("busy_done_overlap", 1, 0);
            if (!busy && n == 0) n = i;
        end
    endtask

    task automatic chk_all_zero(input string name);
        for (int a = 0; a < 16; a++) begin
            address = 4'(a);
            raddr2  = 4'(15 - a);
            #1;
            chk({name, "_out"}, out, 0);
            chk({name, "_out2"}, out2, 0);
        end
    endtask

    vec_t vecs[7];
    int n, nd, dat;

    initial begin
        vecs[0] = '{1'b1, 4'd5,  16'h1234, 4'd5,  16'h1234, 16'h1234};
        vecs[1] = '{1'b0, 4'd6,  16'h0000, 4'd5,  16'h0000, 16'h1234};
        vecs[2] = '{1'b1, 4'd6,  16'h5678, 4'd5,  16'h5678, 16'h1234};
        vecs[3] = '{1'b1, 4'd15, 16'hFFFF, 4'd0,  16'hFFFF, 16'h0000};
        vecs[4] = '{1'b1, 4'd0,  16'hA5A5, 4'd15, 16'hA5A5, 16'hFFFF};
        vecs[5] = '{1'b1, 4'd5,  16'h0001, 4'd6,  16'h0001, 16'h5678};
        vecs[6] = '{1'b0, 4'd5,  16'hDEAD, 4'd0,  16'h0001, 16'hA5A5};

        #2 reset = 1'b0;
        #1;
        chk("rst_busy", busy, 1);
        chk("rst_done", done, 0);
        chk("rst_busy_nc", busy_nc, 0);
        chk("rst_done_nc", done_nc, 0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;

        measure(-1, n, nd, dat);
        chk("init_busy_cycles", n, 16);
        chk("init_done_count", nd, 1);
        chk("init_done_edge", dat, 16);
        chk("init_nc_idle", busy_nc, 0);
        chk_all_zero("init_zero");

        for (int i = 0; i < 7; i++) begin
            load = vecs[i].ld; address = vecs[i].a; in = vecs[i].d; raddr2 = vecs[i].r2;
            tick();
            load = 1'b0;
            chk($sformatf("vec%0d_out", i), out, vecs[i].eo);
            chk($sformatf("vec%0d_out2", i), out2, vecs[i].eo2);
        end
        address = 4'd5; raddr2 = 4'd6; #1;
        chk("nc_out", out_nc, 16'h0001);
        chk("nc_out2", out2_nc, 16'h5678);

        // load ignored during a sweep, outputs forced low
        clear = 1'b1; tick(); clear = 1'b0;
        chk("sweep_busy", busy, 1);
        load = 1'b1; address = 4'd3; in = 16'hBEEF; raddr2 = 4'd3;
        tick();
        load = 1'b0;
        chk("sweep_out_forced", out, 0);
        chk("sweep_out2_forced", out2, 0);
        measure(-1, n, nd, dat);
        chk("sweep_rest_cycles", n, 15);
        chk("sweep_done_count", nd, 1);
        address = 4'd3; #1;
        chk("sweep_m3", out, 0);
        chk_all_zero("sweep_zero");

        // same-edge clear and load: clear wins
        for (int a = 0; a < 16; a++) begin
            load = 1'b1; address = 4'(a); in = 16'hFFFF;
            tick();
        end
        load = 1'b0; address = 4'd7; #1;
        chk("fill_m7", out, 16'hFFFF);
        clear = 1'b1; load = 1'b1; address = 4'd2; in = 16'hAAAA;
        tick();
        clear = 1'b0; load = 1'b0;
        chk("prio_busy", busy, 1);
        chk("prio_out_forced", out, 0);
        measure(-1, n, nd, dat);
        chk("prio_busy_cycles", n, 16);
        chk("prio_done_count", nd, 1);
        chk_all_zero("prio_zero");

        // reset at cnt=7 restarts a full sweep
        clear = 1'b1; tick(); clear = 1'b0;
        repeat (7) tick();
        chk("abort_busy_before", busy, 1);
        reset = 1'b0; #1;
        chk("abort_busy_rst", busy, 1);
        chk("abort_done_rst", done, 0);
        chk("abort_nc_idle", busy_nc, 0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        measure(-1, n, nd, dat);
        chk("abort_busy_cycles", n, 16);
        chk("abort_done_count", nd, 1);

        // clear mid-sweep neither restarts nor extends
        clear = 1'b1; tick(); clear = 1'b0;
        measure(10, n, nd, dat);
        chk("reclr_busy_cycles", n, 16);
        chk("reclr_done_count", nd, 1);
        chk("reclr_done_edge", dat, 16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ram_clr.md
RAM_CLR -- requirements
Module: ram_clr

Interface
REQ-001 Parameter WIDTH, default 16: data word width in bits.
REQ-002 Parameter AWIDTH, default 14: address width; DEPTH = 2**AWIDTH words.
REQ-003 Parameter INIT_CLEAR, default 1: 1 = run a full clear sweep after every reset release; 0 = go idle after reset.
REQ-004 clock  input  1  single clock; all state changes on posedge.
REQ-005 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 in  input  WIDTH  write data.
REQ-007 load  input  1  write enable for port A.
REQ-008 address  input  AWIDTH  port A read/write address.
REQ-009 out  output  WIDTH  port A read data, combinational from address.
REQ-010 raddr2  input  AWIDTH  port B read-only address.
REQ-011 out2  output  WIDTH  port B read data, combinational from raddr2.
REQ-012 clear  input  1  request a clear of all words to zero.
REQ-013 busy  output  1  high while a clear sweep is in progress.
REQ-014 done  output  1  one-cycle pulse when a clear sweep completes.

Function
REQ-015 FSM states: IDLE and CLEAR; sweep counter cnt is AWIDTH bits wide.
REQ-016 IDLE behaviour: a posedge with load=1 writes in to m[address].
REQ-017 IDLE behaviour: out = m[address] and out2 = m[raddr2], combinational, with no read latency.
REQ-018 Write-then-read to the same address: new data appears on out/out2 immediately after the writing edge (no old-data bypass, no same-edge forwarding).
REQ-019 IDLE to CLEAR: clear=1 at a posedge loads cnt=0 and sets busy=1 from the next cycle.
REQ-020 Same-edge clear and load in IDLE: clear takes priority and the load write is discarded.
REQ-021 CLEAR behaviour: each posedge writes 0 to m[cnt], then increments cnt; a full sweep is exactly DEPTH cycles.
REQ-022 CLEAR exit: on the edge that writes m[DEPTH-1], the FSM moves to IDLE, busy falls, and done=1 for exactly the following cycle.
REQ-023 cnt does not wrap and is not reused after DEPTH-1; it is only reloaded on entry to CLEAR.
REQ-024 While busy=1: load is ignored (no write to the array).
REQ-025 While busy=1: clear is ignored (no restart, no extension).
REQ-026 While busy=1: out and out2 are forced to 0, regardless of partially cleared contents.
REQ-027 done is never high in the same cycle as busy.
REQ-028 Arithmetic: cnt increments modulo nothing; the DEPTH-1 terminal compare is exact; address inputs are used unmodified at AWIDTH bits.

Reset
REQ-029 Reset assertion forces, asynchronously: cnt=0 and done=0.
REQ-030 Reset assertion forces state=CLEAR with busy=1 if INIT_CLEAR=1; otherwise state=IDLE with busy=0.
REQ-031 Reset does not itself modify array contents; with INIT_CLEAR=0, contents after reset are undefined until written.
REQ-032 Reset during a sweep: the sweep aborts immediately and, if INIT_CLEAR=1, restarts from cnt=0 after release for a full DEPTH cycles.
REQ-033 First active edge after reset release with INIT_CLEAR=1: writes m[0].

Verification (WIDTH=16, AWIDTH=4, DEPTH=16)
REQ-034 INIT_CLEAR=1 reset release -> busy=1 for exactly 16 cycles, done=1 on cycle 17 only, then all 16 addresses read 0x0000 on out and out2.
REQ-035 IDLE, load=1, address=5, in=0x1234 -> after edge, out=0x1234; raddr2=5 gives out2=0x1234; address=6 still reads 0x0000.
REQ-036 During sweep, load=1, address=3, in=0xBEEF -> ignored; out=0 while busy; m[3]=0x0000 after done.
REQ-037 Fill all words with 0xFFFF, then clear=1 and load=1 (address=2, in=0xAAAA) on the same edge -> no write; after 16 busy cycles, all words = 0x0000.
REQ-038 Reset asserted at cnt=7 mid-sweep, released 2 cycles later -> busy stays 1, a fresh full 16-cycle sweep runs, single done pulse.
REQ-039 clear pulsed at sweep cycle 10 -> sweep still ends at cycle 16, exactly one done pulse; INIT_CLEAR=0 build -> busy=0 immediately after reset.
